// File: rtl/and_pulse_scheduler.sv
// Issues toggle edges on the a, b and clk inputs of a basic_and cell from three requesters,
// keeping a minimum edge spacing and the cell's legal a/b/clk ordering, and mirrors the cell output.
module and_pulse_scheduler #(
  parameter int GAP_CYCLES = 3,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_req,
  output logic             a_ack,
  input  logic             b_req,
  output logic             b_ack,
  input  logic             c_req,
  output logic             c_ack,
  output logic             a_pulse,
  output logic             b_pulse,
  output logic             clk_pulse,
  output logic [1:0]       mirror_state,
  output logic             exp_out,
  output logic             busy,
  output logic [CNT_W-1:0] issue_count
);

  // Counter only needs to hold GAP_CYCLES-1; keep at least one bit when there is no spacing.
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_A    = 2'd1,
    ST_B    = 2'd2,
    ST_AB   = 2'd3
  } mirror_t;

  mirror_t          state_q, state_d;
  logic             a_pulse_q, a_pulse_d;
  logic             b_pulse_q, b_pulse_d;
  logic             clk_pulse_q, clk_pulse_d;
  logic             exp_out_q, exp_out_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [CNT_W-1:0] issue_count_q, issue_count_d;

  logic gap_clear;
  logic a_elig;
  logic b_elig;
  logic any_issue;

  // Grant: one ack per cycle, fixed priority A > B > C among eligible requesters.
  always_comb begin
    gap_clear = (gap_q == '0) && !rst;
    a_elig    = (state_q == ST_IDLE) || (state_q == ST_B);
    b_elig    = (state_q == ST_IDLE) || (state_q == ST_A);
    a_ack     = gap_clear && a_req && a_elig;
    b_ack     = gap_clear && b_req && b_elig && !a_ack;
    c_ack     = gap_clear && c_req && !a_ack && !b_ack;
    any_issue = a_ack || b_ack || c_ack;
  end

  always_comb begin
    state_d       = state_q;
    a_pulse_d     = a_pulse_q;
    b_pulse_d     = b_pulse_q;
    clk_pulse_d   = clk_pulse_q;
    exp_out_d     = exp_out_q;
    gap_d         = gap_q;
    issue_count_d = issue_count_q;

    if (gap_q != '0) begin
      gap_d = gap_q - GAP_W'(1);
    end

    if (any_issue) begin
      gap_d         = GAP_LOAD;
      issue_count_d = issue_count_q + CNT_W'(1);
    end

    if (a_ack) begin
      a_pulse_d = ~a_pulse_q;
      case (state_q)
        ST_IDLE: state_d = ST_A;
        ST_B:    state_d = ST_AB;
        default: state_d = state_q;
      endcase
    end else if (b_ack) begin
      b_pulse_d = ~b_pulse_q;
      case (state_q)
        ST_IDLE: state_d = ST_B;
        ST_A:    state_d = ST_AB;
        default: state_d = state_q;
      endcase
    end else if (c_ack) begin
      // Evaluating with both operands seen flips the predicted AND output.
      clk_pulse_d = ~clk_pulse_q;
      state_d     = ST_IDLE;
      if (state_q == ST_AB) begin
        exp_out_d = ~exp_out_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      a_pulse_q     <= 1'b0;
      b_pulse_q     <= 1'b0;
      clk_pulse_q   <= 1'b0;
      exp_out_q     <= 1'b0;
      gap_q         <= '0;
      issue_count_q <= '0;
    end else begin
      state_q       <= state_d;
      a_pulse_q     <= a_pulse_d;
      b_pulse_q     <= b_pulse_d;
      clk_pulse_q   <= clk_pulse_d;
      exp_out_q     <= exp_out_d;
      gap_q         <= gap_d;
      issue_count_q <= issue_count_d;
    end
  end

  assign a_pulse      = a_pulse_q;
  assign b_pulse      = b_pulse_q;
  assign clk_pulse    = clk_pulse_q;
  assign mirror_state = state_q;
  assign exp_out      = exp_out_q;
  assign busy         = (gap_q != '0);
  assign issue_count  = issue_count_q;

endmodule

// File: tb/tb_and_pulse_scheduler.sv
// Randomized and directed bench for and_pulse_scheduler against a behavioural model
// that tracks operand-seen flags, the time of the last issued edge and a running count.
module tb_and_pulse_scheduler;
  localparam int GAP = 3;
  localparam int CW  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_req, b_req, c_req;
  logic          a_ack, b_ack, c_ack;
  logic          a_pulse, b_pulse, clk_pulse;
  logic [1:0]    mirror_state;
  logic          exp_out, busy;
  logic [CW-1:0] issue_count;
  logic [17:0]   dut_vec;

  and_pulse_scheduler #(.GAP_CYCLES(GAP), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_ack(a_ack),
    .b_req(b_req), .b_ack(b_ack),
    .c_req(c_req), .c_ack(c_ack),
    .a_pulse(a_pulse), .b_pulse(b_pulse), .clk_pulse(clk_pulse),
    .mirror_state(mirror_state), .exp_out(exp_out), .busy(busy),
    .issue_count(issue_count)
  );

  always #5 clk = ~clk;

  assign dut_vec = {a_ack, b_ack, c_ack, a_pulse, b_pulse, clk_pulse,
                    mirror_state, exp_out, busy, issue_count};

  int n_checks = 0;
  int n_fail   = 0;

  // Model: cyc numbers the upcoming rising edge; m_last is the edge of the last issue.
  int cyc    = 0;
  int m_last = -1000;
  int m_cnt  = 0;
  bit m_a, m_b, m_exp, m_ap, m_bp, m_cp;

  function automatic logic [2:0] model_acks();
    if (rst || (cyc - m_last) < GAP) return 3'b000;
    if (a_req && !m_a) return 3'b100;
    if (b_req && !m_b) return 3'b010;
    if (c_req) return 3'b001;
    return 3'b000;
  endfunction

  function automatic logic [17:0] model_vec();
    logic bz;
    bz = ((cyc - m_last) < GAP) ? 1'b1 : 1'b0;
    return {model_acks(), m_ap, m_bp, m_cp, m_b, m_a, m_exp, bz, m_cnt[7:0]};
  endfunction

  // Advance one rising edge, updating the model from the inputs present at that edge.
  task automatic advance();
    logic [2:0] g;
    g = model_acks();
    @(posedge clk);
    if (rst) begin
      m_a = 0; m_b = 0; m_exp = 0; m_ap = 0; m_bp = 0; m_cp = 0;
      m_cnt = 0; m_last = -1000;
    end else if (g != 3'b000) begin
      m_cnt  = (m_cnt + 1) % 256;
      m_last = cyc;
      if (g[2]) begin
        m_ap = !m_ap; m_a = 1;
      end else if (g[1]) begin
        m_bp = !m_bp; m_b = 1;
      end else begin
        m_cp = !m_cp;
        if (m_a && m_b) m_exp = !m_exp;
        m_a = 0; m_b = 0;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      advance();
    end
  endtask

  function automatic logic ack_of(input int which);
    case (which)
      0:       return a_ack;
      1:       return b_ack;
      default: return c_ack;
    endcase
  endfunction

  task automatic set_req(input int which, input logic v);
    case (which)
      0:       a_req = v;
      1:       b_req = v;
      default: c_req = v;
    endcase
  endtask

  // Raise one request and wait (bounded) for its transfer; report the edge number.
  task automatic pulse_req(input int which, input bit hold, output int at, output bit ok);
    ok = 0;
    at = -1;
    set_req(which, 1'b1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ack_of(which)) begin
        at = cyc;
        ok = 1;
        advance();
        break;
      end
      advance();
    end
    if (!hold) set_req(which, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1; a_req = 1; b_req = 1; c_req = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if ({a_ack, b_ack, c_ack} !== 3'b000) begin
        n_fail++;
        $display("FAIL reset_acks: got %b want 000", {a_ack, b_ack, c_ack});
      end
      n_checks++;
      if (dut_vec !== 18'h0) begin
        n_fail++;
        $display("FAIL reset_state: got %h want 0", dut_vec);
      end
      advance();
    end
    rst = 0; a_req = 0; b_req = 0; c_req = 0;
  endtask

  task automatic test_and_seq();
    int  c0, ta, tb, tc;
    bit  oka, okb, okc;
    logic [1:0] ms[3];
    c0 = cyc;
    pulse_req(0, 0, ta, oka); ms[0] = mirror_state;
    pulse_req(1, 0, tb, okb); ms[1] = mirror_state;
    pulse_req(2, 0, tc, okc); ms[2] = mirror_state;
    n_checks++;
    if (!(oka && okb && okc)) begin
      n_fail++;
      $display("FAIL and_seq_timeout: got %b%b%b want 111", oka, okb, okc);
    end
    n_checks++;
    if (ta != c0) begin
      n_fail++;
      $display("FAIL and_seq_latency: got edge %0d want %0d", ta, c0);
    end
    n_checks++;
    if ((tb - ta) != GAP || (tc - tb) != GAP) begin
      n_fail++;
      $display("FAIL and_seq_spacing: got %0d,%0d want %0d,%0d", tb - ta, tc - tb, GAP, GAP);
    end
    n_checks++;
    if (ms[0] !== 2'd1 || ms[1] !== 2'd3 || ms[2] !== 2'd0) begin
      n_fail++;
      $display("FAIL and_seq_mirror: got %0d,%0d,%0d want 1,3,0", ms[0], ms[1], ms[2]);
    end
    n_checks++;
    if (exp_out !== 1'b1 || issue_count !== 8'd3) begin
      n_fail++;
      $display("FAIL and_seq_result: got exp_out=%b count=%0d want 1, 3", exp_out, issue_count);
    end
  endtask

  task automatic test_simultaneous();
    int order[3];
    int when[3];
    int k;
    k = 0;
    idle(GAP);
    a_req = 1; b_req = 1; c_req = 1;
    for (int i = 0; i < 30 && k < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (dut_vec !== model_vec()) begin
        n_fail++;
        $display("FAIL simul_cycle: edge %0d got %h want %h", cyc, dut_vec, model_vec());
      end
      if (a_ack || b_ack || c_ack) begin
        order[k] = a_ack ? 0 : (b_ack ? 1 : 2);
        when[k]  = cyc;
        advance();
        set_req(order[k], 1'b0);
        k++;
      end else begin
        advance();
      end
    end
    n_checks++;
    if (k != 3 || order[0] != 0 || order[1] != 1 || order[2] != 2) begin
      n_fail++;
      $display("FAIL simul_order: got k=%0d %0d,%0d,%0d want 3 0,1,2", k, order[0], order[1], order[2]);
    end
    n_checks++;
    if ((when[1] - when[0]) != GAP || (when[2] - when[1]) != GAP) begin
      n_fail++;
      $display("FAIL simul_spacing: got %0d,%0d want %0d,%0d", when[1] - when[0], when[2] - when[1], GAP, GAP);
    end
    a_req = 0; b_req = 0; c_req = 0;
  endtask

  task automatic test_blocked();
    int  ta, tc, ta2;
    bit  ok1, ok2, ok3;
    idle(GAP);
    pulse_req(0, 1, ta, ok1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_checks++;
      if (a_ack !== 1'b0 || mirror_state !== 2'd1) begin
        n_fail++;
        $display("FAIL blocked_dup: got a_ack=%b state=%0d want 0, 1", a_ack, mirror_state);
      end
      advance();
    end
    pulse_req(2, 0, tc, ok2);
    n_checks++;
    if (mirror_state !== 2'd0) begin
      n_fail++;
      $display("FAIL blocked_clear: got state=%0d want 0", mirror_state);
    end
    pulse_req(0, 0, ta2, ok3);
    n_checks++;
    if (!(ok1 && ok2 && ok3) || (ta2 - tc) != GAP) begin
      n_fail++;
      $display("FAIL blocked_regrant: got ok=%b%b%b delta=%0d want 111 %0d", ok1, ok2, ok3, ta2 - tc, GAP);
    end
  endtask

  task automatic test_single();
    int  t;
    bit  ok1, ok2, ok3;
    logic e0;
    idle(GAP);
    pulse_req(2, 0, t, ok1);
    e0 = exp_out;
    pulse_req(1, 0, t, ok2);
    n_checks++;
    if (mirror_state !== 2'd2) begin
      n_fail++;
      $display("FAIL single_b: got state=%0d want 2", mirror_state);
    end
    pulse_req(2, 0, t, ok3);
    n_checks++;
    if (!(ok1 && ok2 && ok3) || mirror_state !== 2'd0 || exp_out !== e0) begin
      n_fail++;
      $display("FAIL single_eval: got ok=%b%b%b state=%0d exp_out=%b want 111 0 %b",
               ok1, ok2, ok3, mirror_state, exp_out, e0);
    end
  endtask

  task automatic test_reset_mid();
    int  t;
    bit  ok1, ok2;
    idle(GAP);
    pulse_req(0, 0, t, ok1);
    pulse_req(1, 0, t, ok2);
    n_checks++;
    if (!(ok1 && ok2) || mirror_state !== 2'd3 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_setup: got ok=%b%b state=%0d busy=%b want 11 3 1", ok1, ok2, mirror_state, busy);
    end
    rst = 1; a_req = 1;
    @(negedge clk);
    n_checks++;
    if ({a_ack, b_ack, c_ack} !== 3'b000) begin
      n_fail++;
      $display("FAIL rstmid_acks: got %b want 000", {a_ack, b_ack, c_ack});
    end
    advance();
    rst = 0;
    @(negedge clk);
    n_checks++;
    if (dut_vec !== {3'b100, 15'h0}) begin
      n_fail++;
      $display("FAIL rstmid_after: got %h want %h", dut_vec, {3'b100, 15'h0});
    end
    advance();
    a_req = 0;
    n_checks++;
    if (a_pulse !== 1'b1 || mirror_state !== 2'd1 || issue_count !== 8'd1) begin
      n_fail++;
      $display("FAIL rstmid_fresh: got a_pulse=%b state=%0d count=%0d want 1 1 1", a_pulse, mirror_state, issue_count);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      a_req = ($urandom_range(0, 99) < 45);
      b_req = ($urandom_range(0, 99) < 45);
      c_req = ($urandom_range(0, 99) < 35);
      rst   = ($urandom_range(0, 99) < 2);
      @(negedge clk);
      n_checks++;
      if (dut_vec !== model_vec()) begin
        n_fail++;
        $display("FAIL random_cycle: edge %0d got %h want %h", cyc, dut_vec, model_vec());
      end
      advance();
    end
    rst = 0; a_req = 0; b_req = 0; c_req = 0;
  endtask

  task automatic test_wrap();
    bit saw_wrap;
    logic [CW-1:0] prev;
    saw_wrap = 0;
    prev = issue_count;
    c_req = 1;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      n_checks++;
      if (dut_vec !== model_vec()) begin
        n_fail++;
        $display("FAIL wrap_cycle: edge %0d got %h want %h", cyc, dut_vec, model_vec());
      end
      if (prev == 8'd255 && issue_count == 8'd0) saw_wrap = 1;
      prev = issue_count;
      advance();
    end
    c_req = 0;
    n_checks++;
    if (!saw_wrap) begin
      n_fail++;
      $display("FAIL wrap_seen: got no 255->0 transition want one");
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1; a_req = 0; b_req = 0; c_req = 0;
    @(negedge clk);
    advance();
    test_reset();
    test_and_seq();
    test_simultaneous();
    test_blocked();
    test_single();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
